// File: rtl/life_array_grid.sv
// Parametrised ROWS x COLS Game-of-Life array with edge-triggered load/step and a multi-generation run engine.
// Optional LIFE_TORUS_EN wraps the array toroidally; otherwise boundary neighbours come from n/s/e/w/corner ports.
module life_array_grid #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] val,
    input  logic                 write_enb,
    input  logic                 step,
    input  logic                 run_start,
    input  logic [GEN_W-1:0]     run_len,
    input  logic [COLS-1:0]      n,
    input  logic [COLS-1:0]      s,
    input  logic [ROWS-1:0]      w,
    input  logic [ROWS-1:0]      e,
    input  logic                 nw,
    input  logic                 ne,
    input  logic                 sw,
    input  logic                 se,
    output logic [ROWS*COLS-1:0] alive,
    output logic [ROWS*COLS-1:0] alive_prev,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 busy,
    output logic                 done,
    output logic                 stable,
    output logic                 extinct
);

    localparam int N  = ROWS * COLS;
    localparam int PW = COLS + 2;
    localparam int PH = ROWS + 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [GEN_W-1:0] remaining;
    logic             we_q;
    logic             step_q;
    logic             load_fire;
    logic             step_fire;
    logic [PH*PW-1:0] pad;
    logic [N-1:0]     next_gen;
    logic [3:0]       cnt;

`ifdef LIFE_TORUS_EN
    logic unused_edges;
    assign unused_edges = ^{n, s, w, e, nw, ne, sw, se};

    // Padded ring is filled from the opposite edge so every cell sees a wrapped neighbourhood.
    always_comb begin
        pad = '0;
        for (int r = 0; r < PH; r++) begin
            for (int c = 0; c < PW; c++) begin
                pad[r*PW+c] = alive[((r + ROWS - 1) % ROWS) * COLS + ((c + COLS - 1) % COLS)];
            end
        end
    end
`else
    logic [PW-1:0] top_row;
    logic [PW-1:0] bot_row;
    assign top_row = {ne, n, nw};
    assign bot_row = {se, s, sw};

    always_comb begin
        pad = '0;
        for (int r = 0; r < PH; r++) begin
            for (int c = 0; c < PW; c++) begin
                if (r == 0)
                    pad[r*PW+c] = top_row[c];
                else if (r == PH - 1)
                    pad[r*PW+c] = bot_row[c];
                else if (c == 0)
                    pad[r*PW+c] = w[r-1];
                else if (c == PW - 1)
                    pad[r*PW+c] = e[r-1];
                else
                    pad[r*PW+c] = alive[(r-1)*COLS + (c-1)];
            end
        end
    end
`endif

    // Cell (r,c) sits at padded (r+1,c+1), so its neighbourhood spans padded rows r..r+2.
    always_comb begin
        next_gen = '0;
        cnt      = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 4'(pad[r*PW+c])       + 4'(pad[r*PW+c+1])       + 4'(pad[r*PW+c+2])
                    + 4'(pad[(r+1)*PW+c])                             + 4'(pad[(r+1)*PW+c+2])
                    + 4'(pad[(r+2)*PW+c])   + 4'(pad[(r+2)*PW+c+1])   + 4'(pad[(r+2)*PW+c+2]);
                next_gen[r*COLS+c] = (cnt == 4'd3) | (alive[r*COLS+c] & (cnt == 4'd2));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            remaining  <= '0;
            we_q       <= 1'b0;
            step_q     <= 1'b0;
            load_fire  <= 1'b0;
            step_fire  <= 1'b0;
            alive      <= '0;
            alive_prev <= '0;
            gen_count  <= '0;
            done       <= 1'b0;
        end else begin
            we_q      <= write_enb;
            step_q    <= step;
            load_fire <= write_enb & ~we_q;
            step_fire <= step & ~step_q;
            done      <= 1'b0;
            if (load_fire) begin
                // A load aborts any run silently.
                alive      <= val;
                alive_prev <= val;
                gen_count  <= '0;
                state      <= S_IDLE;
            end else if (state == S_IDLE) begin
                if (step_fire) begin
                    alive_prev <= alive;
                    alive      <= next_gen;
                    gen_count  <= gen_count + 1'b1;
                end else if (run_start) begin
                    if (run_len == '0) begin
                        done <= 1'b1;
                    end else begin
                        state     <= S_RUN;
                        remaining <= run_len;
                    end
                end
            end else begin
                alive_prev <= alive;
                alive      <= next_gen;
                gen_count  <= gen_count + 1'b1;
                remaining  <= remaining - 1'b1;
                if (remaining == GEN_W'(1) || next_gen == '0) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign busy    = (state == S_RUN);
    assign stable  = (alive == alive_prev);
    assign extinct = (alive == '0);

endmodule

// File: tb/tb_life_array_grid.sv
// Randomised and directed bench for life_array_grid against a grid-array reference model.
module tb_life_array_grid;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int GEN_W = 16;
    localparam int N     = ROWS * COLS;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     val;
    logic             write_enb;
    logic             step;
    logic             run_start;
    logic [GEN_W-1:0] run_len;
    logic [COLS-1:0]  n, s;
    logic [ROWS-1:0]  w, e;
    logic             nw, ne, sw, se;
    logic [N-1:0]     alive, alive_prev;
    logic [GEN_W-1:0] gen_count;
    logic             busy, done, stable, extinct;

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0]     m_alive;
    logic [N-1:0]     m_prev;
    logic [GEN_W-1:0] m_gen;

    life_array_grid #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
        .clk(clk), .reset(reset), .val(val), .write_enb(write_enb), .step(step),
        .run_start(run_start), .run_len(run_len), .n(n), .s(s), .w(w), .e(e),
        .nw(nw), .ne(ne), .sw(sw), .se(se), .alive(alive), .alive_prev(alive_prev),
        .gen_count(gen_count), .busy(busy), .done(done), .stable(stable), .extinct(extinct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Value of the cell at (r,c), which may lie outside the array.
    function automatic int cell_at(input logic [N-1:0] g, input int r, input int c);
`ifdef LIFE_TORUS_EN
        return int'(g[((r + ROWS) % ROWS) * COLS + ((c + COLS) % COLS)]);
`else
        if (r < 0) begin
            if (c < 0) return int'(nw);
            if (c >= COLS) return int'(ne);
            return int'(n[c]);
        end
        if (r >= ROWS) begin
            if (c < 0) return int'(sw);
            if (c >= COLS) return int'(se);
            return int'(s[c]);
        end
        if (c < 0) return int'(w[r]);
        if (c >= COLS) return int'(e[r]);
        return int'(g[r*COLS+c]);
`endif
    endfunction

    function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
        logic [N-1:0] res;
        int k;
        res = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                k = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) k += cell_at(g, r + dr, c + dc);
                if (g[r*COLS+c]) res[r*COLS+c] = (k == 2 || k == 3);
                else             res[r*COLS+c] = (k == 3);
            end
        end
        return res;
    endfunction

    function automatic void model_gen();
        m_prev  = m_alive;
        m_alive = life_next(m_alive);
        m_gen   = m_gen + 1'b1;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".alive"},   64'(alive),      64'(m_alive));
        chk({tag, ".prev"},    64'(alive_prev), 64'(m_prev));
        chk({tag, ".gen"},     64'(gen_count),  64'(m_gen));
        chk({tag, ".busy"},    64'(busy),       64'(0));
        chk({tag, ".stable"},  64'(stable),     64'(m_alive == m_prev));
        chk({tag, ".extinct"}, 64'(extinct),    64'(m_alive == '0));
    endtask

    task automatic do_load(input logic [N-1:0] v);
        val = v;
        write_enb = 1'b1;
        @(negedge clk);
        write_enb = 1'b0;
        @(negedge clk);
        m_alive = v;
        m_prev  = v;
        m_gen   = '0;
    endtask

    task automatic do_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        model_gen();
    endtask

    // Runs len generations and checks busy length, a single done pulse and its alignment with busy falling.
    task automatic do_run(input string tag, input int len);
        int exp_gens, busy_cnt, done_cnt, done_idx;
        exp_gens = 0;
        while (exp_gens < len) begin
            model_gen();
            exp_gens++;
            if (m_alive == '0) break;
        end
        run_len = GEN_W'(len);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        for (int i = 0; i < len + 4; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_gens));
        chk({tag, ".done_pulses"}, 64'(done_cnt), 64'(1));
        chk({tag, ".done_at_fall"}, 64'(done_idx), 64'(exp_gens));
        check_state(tag);
    endtask

    initial begin
        int done_seen;
        reset = 1'b0;
        val = '0; write_enb = 1'b0; step = 1'b0; run_start = 1'b0; run_len = '0;
        n = '0; s = '0; w = '0; e = '0; nw = 1'b0; ne = 1'b0; sw = 1'b0; se = 1'b0;
        m_alive = '0; m_prev = '0; m_gen = '0;
        repeat (2) @(negedge clk);
        check_state("por");
        reset = 1'b1;
        @(negedge clk);

        // Blinker: a held step level must advance exactly one generation.
        do_load(N'(16'h0070));
        check_state("load_blinker");
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        model_gen();
        check_state("held_step");
`ifndef LIFE_TORUS_EN
        chk("blinker_vert", 64'(alive), 64'h0222);
`endif
        do_step();
        check_state("blinker_back");

        do_load(N'(16'h0660));
        do_step();
        check_state("block_still");
        chk("block_stable", 64'(stable), 64'(1));
        do_load(N'(16'hCC33));
        do_step();
        check_state("two_blocks");
`ifndef LIFE_TORUS_EN
        chk("two_blocks_const", 64'(alive), 64'hC813);
        n = 4'b0001; w = 4'b0001; nw = 1'b1;
        do_load('0);
        do_step();
        check_state("edge_birth");
        chk("edge_birth_const", 64'(alive), 64'h0001);
        n = '0; w = '0; nw = 1'b0;
`endif
        do_load(N'(16'h0007));
        do_step();
        check_state("row0_blinker");
`ifdef LIFE_TORUS_EN
        chk("torus_const", 64'(alive), 64'h2022);
`else
        chk("flat_const", 64'(alive), 64'h0022);
`endif

        do_load(N'(16'h0070));
        do_run("run3", 3);
        do_load(N'(16'h0001));
        do_run("run_extinct", 5);
        do_run("run_zero", 0);

        // A load mid-run aborts without a done pulse.
        do_load(N'(16'h0070));
        run_len = GEN_W'(10);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 2; i++) begin
            done_seen += int'(done);
            @(negedge clk);
        end
        chk("abort.busy_mid", 64'(busy), 64'(1));
        val = N'(16'h0660);
        write_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            done_seen += int'(done);
            @(negedge clk);
            write_enb = 1'b0;
        end
        m_alive = N'(16'h0660); m_prev = N'(16'h0660); m_gen = '0;
        chk("abort.no_done", 64'(done_seen), 64'(0));
        check_state("abort");

        // Reset in the middle of a run clears everything with no done pulse.
        do_load(N'(16'h0070));
        run_len = GEN_W'(20);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        m_alive = '0; m_prev = '0; m_gen = '0;
        check_state("mid_reset");
        chk("mid_reset.done", 64'(done), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("after_reset.done", 64'(done), 64'(0));
        chk("after_reset.busy", 64'(busy), 64'(0));

        for (int it = 0; it < 40; it++) begin
            n = COLS'($urandom); s = COLS'($urandom);
            w = ROWS'($urandom); e = ROWS'($urandom);
            {nw, ne, sw, se} = 4'($urandom);
            do_load(N'($urandom));
            case ($urandom_range(0, 2))
                0: begin
                    do_step();
                    check_state("rnd_step");
                end
                1: do_run("rnd_run", int'($urandom_range(0, 6)));
                default: begin
                    do_step();
                    do_step();
                    check_state("rnd_step2");
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/life_array_grid.md
Name: life_array_grid

Overview:
- Parametrised ROWS x COLS Conway Game-of-Life cell array; successor to the fixed 4x4 array.
- Holds current and previous generations, with boundary neighbour inputs for tiling.
- Adds edge-triggered load/step, a multi-generation run engine with busy/done handshake, generation counter, and stable/extinct flags.
- Sits between the pattern loader and the display scanner.

Parameters:
ROWS, 4, number of cell rows (>=2)
COLS, 4, number of cell columns (>=2)
GEN_W, 16, width of generation counter and run length

Ports:
clk  in  1  system clock
reset  in  1  reset; asynchronous, active-low
val  in  ROWS*COLS  pattern to load; bit r*COLS+c = row r (0 top), col c (0 left)
write_enb  in  1  load request; rising edge loads val
step  in  1  single-generation request; rising edge advances one generation
run_start  in  1  start multi-generation run; sampled only in IDLE
run_len  in  GEN_W  generations to run; captured with run_start
n  in  COLS  cells above row 0, n[c] above column c
s  in  COLS  cells below row ROWS-1
w  in  ROWS  cells left of column 0, w[r] beside row r
e  in  ROWS  cells right of column COLS-1
nw, ne, sw, se  in  1 each  diagonal corner neighbours
alive  out  ROWS*COLS  current generation
alive_prev  out  ROWS*COLS  generation before the last update
gen_count  out  GEN_W  generations since last load
busy  out  1  high while RUN
done  out  1  one-cycle pulse at run completion
stable  out  1  alive == alive_prev
extinct  out  1  alive == 0

Behaviour:
- Reset (reset=0, async):
  - alive, alive_prev, gen_count = 0; busy = done = 0.
  - Edge-detect registers = 0.
  - FSM returns to IDLE.
  - Applies mid-run too; no done pulse is issued.
- Rules:
  - Live cell with 2 or 3 live neighbours survives.
  - Dead cell with exactly 3 is born.
  - All other cells are dead next generation.
  - Neighbour count is 4 bits, summed combinationally over the 8 neighbours.
  - Out-of-array neighbours come from n/s/e/w/corner ports.
- Edge detection:
  - write_enb and step are registered each clock.
  - An action fires only on a 0->1 transition; holding a level high causes exactly one action.
- Load (write_enb edge):
  - Next clock: alive <= val, alive_prev <= val, gen_count <= 0.
  - Allowed in any state; in RUN it aborts the run (busy->0, no done pulse).
- Step (step edge, IDLE only):
  - Next clock: alive_prev <= alive, alive <= next_gen, gen_count <= gen_count+1.
  - gen_count wraps modulo 2^GEN_W.
  - Step edges in RUN are ignored.
- Priority: load > step > run_start when they coincide.
- FSM states:
  - IDLE: run_start=1 with no load/step edge -> capture run_len into remaining.
    - remaining==0: stay IDLE, pulse done next cycle, no generation change.
    - Otherwise go to RUN; busy=1 from the following cycle.
  - RUN: one generation per clock (same update as step); remaining decrements.
    - Exit to IDLE after the last generation, or early when the new generation is extinct.
    - done pulses the cycle busy falls.
    - Run of N (no early exit): busy high N cycles, gen_count +N.
- Flags:
  - stable and extinct are combinational from the registered alive/alive_prev.
  - stable=1 immediately after a load (alive_prev=val).
- Latency: load/step edge on cycle k -> alive updated at end of cycle k+1 (one edge-detect register stage).

Optional Feature:
- Macro LIFE_TORUS_EN.
- Defined: the array is toroidal.
  - Row 0 neighbours row ROWS-1; column 0 neighbours column COLS-1; corners wrap diagonally.
  - n/s/e/w and corner ports are ignored (left unconnected internally).
- Undefined: boundary neighbours come from the edge ports as above.

Test Plan:
- ROWS=COLS=4, reset low 2 cycles mid-operation -> alive=0, alive_prev=0, gen_count=0, busy=0, extinct=1.
- Load 0x0070, step held high 3 cycles -> alive=0x0222 after exactly one generation, alive_prev=0x0070, gen_count=1; second step edge -> 0x0070.
- Load 0x0660, step -> alive=0x0660, stable=1; load 0xCC33, step -> 0xC813.
- Edge inputs n=4'b0001, w=4'b0001, nw=1, load 0x0000, step -> alive=0x0001, alive_prev=0x0000 (macro undefined).
- Load 0x0070, run_start with run_len=3 -> busy high 3 cycles, done one pulse, alive=0x0222, gen_count=3; load 0x0001 with run_len=5 -> exits after 1 generation (extinct), done pulses; load edge mid-run -> busy drops, no done.
- Load 0x0007, step: LIFE_TORUS_EN undefined -> 0x0022; defined -> 0x2022.
